moller_regmap_v2: RTL and testbench

//  Parametrised AXI4-Lite slave register map for the MOLLER board firmware; successor to the fixed four-register regmap.

---
 rtl/moller_regmap_v2.sv | 244 ++++++++++++++++++++++++
 tb/tb_moller_regmap_v2.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moller_regmap_v2.sv
// MOLLER AXI4-Lite register map: RW control bank, RO status bank, WSTRB writes.
// Optional REGMAP_SLVERR_EN: SLVERR on RO/unmapped writes and unmapped reads.
module moller_regmap_v2 #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 8,
  parameter int          NUM_RW_REGS        = 16,
  parameter int          NUM_RO_REGS        = 8,
  parameter logic [31:0] RW_RESET_VAL       = 32'h0
) (
  input  logic                                      ACLK,
  input  logic                                      ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_AWADDR,
  input  logic [2:0]                                S_AXI_AWPROT,
  input  logic                                      S_AXI_AWVALID,
  output logic                                      S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]           S_AXI_WSTRB,
  input  logic                                      S_AXI_WVALID,
  output logic                                      S_AXI_WREADY,
  output logic [1:0]                                S_AXI_BRESP,
  output logic                                      S_AXI_BVALID,
  input  logic                                      S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_ARADDR,
  input  logic [2:0]                                S_AXI_ARPROT,
  input  logic                                      S_AXI_ARVALID,
  output logic                                      S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_RDATA,
  output logic [1:0]                                S_AXI_RRESP,
  output logic                                      S_AXI_RVALID,
  input  logic                                      S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*NUM_RW_REGS-1:0] ctrl_o,
  output logic [NUM_RW_REGS-1:0]                    wr_pulse_o,
  input  logic [C_S_AXI_DATA_WIDTH*NUM_RO_REGS-1:0] status_i
);

  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int AW   = C_S_AXI_ADDR_WIDTH;
  localparam int IW   = AW - 2;
  localparam int NB   = DW / 8;
  localparam int NREG = NUM_RW_REGS + NUM_RO_REGS;

  localparam logic [1:0] OKAY = 2'b00;
`ifdef REGMAP_SLVERR_EN
  localparam logic [1:0] ERR  = 2'b10;
`else
  localparam logic [1:0] ERR  = 2'b00;
`endif

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  function automatic logic is_rw(input logic [IW-1:0] idx);
    return {1'b0, idx} < (IW+1)'(NUM_RW_REGS);
  endfunction

  function automatic logic is_map(input logic [IW-1:0] idx);
    return {1'b0, idx} < (IW+1)'(NREG);
  endfunction

  // write channel state
  wstate_t           wstate;
  logic              aw_held;
  logic              w_held;
  logic [IW-1:0]     aw_idx_q;
  logic [DW-1:0]     wdata_q;
  logic [NB-1:0]     wstrb_q;
  logic              awready_q;
  logic              wready_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic [DW-1:0]     ctrl_q [NUM_RW_REGS];
  logic [NUM_RW_REGS-1:0] pulse_q;

  // read channel state
  rstate_t           rstate;
  logic              arready_q;
  logic              rvalid_q;
  logic [DW-1:0]     rdata_q;
  logic [1:0]        rresp_q;

  logic              aw_hs;
  logic              w_hs;
  logic              aw_have;
  logic              w_have;
  logic              commit;
  logic [IW-1:0]     c_idx;
  logic [DW-1:0]     c_data;
  logic [NB-1:0]     c_strb;
  logic              c_rw;

  // held AW/W beats take priority over the live bus
  always_comb begin
    aw_hs   = S_AXI_AWVALID & awready_q;
    w_hs    = S_AXI_WVALID & wready_q;
    aw_have = aw_held | aw_hs;
    w_have  = w_held | w_hs;
    c_idx   = aw_held ? aw_idx_q : S_AXI_AWADDR[AW-1:2];
    c_data  = w_held ? wdata_q : S_AXI_WDATA;
    c_strb  = w_held ? wstrb_q : S_AXI_WSTRB;
    commit  = (wstate == W_IDLE) & aw_have & w_have;
    c_rw    = is_rw(c_idx);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate    <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          if (aw_hs) aw_idx_q <= S_AXI_AWADDR[AW-1:2];
          if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
          end
          if (commit) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= c_rw ? OKAY : ERR;
            wstate    <= W_RESP;
          end else begin
            aw_held   <= aw_have;
            w_held    <= w_have;
            awready_q <= ~aw_have;
            wready_q  <= ~w_have;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate    <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // control bank: byte-lane merge and one-cycle commit strobe
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < NUM_RW_REGS; k++)
        ctrl_q[k] <= RW_RESET_VAL;
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      if (commit && c_rw) begin
        for (int k = 0; k < NUM_RW_REGS; k++) begin
          if (c_idx == IW'(k)) begin
            pulse_q[k] <= 1'b1;
            for (int b = 0; b < NB; b++)
              if (c_strb[b])
                ctrl_q[k][8*b +: 8] <= c_data[8*b +: 8];
          end
        end
      end
    end
  end

  logic [IW-1:0] ar_idx;
  logic [DW-1:0] rd_val;
  logic [1:0]    rd_resp;
  logic          ar_hs;

  // read mux sees pre-commit ctrl_q, so a same-edge write is not visible
  always_comb begin
    ar_idx  = S_AXI_ARADDR[AW-1:2];
    ar_hs   = S_AXI_ARVALID & arready_q;
    rd_val  = '0;
    rd_resp = OKAY;
    for (int k = 0; k < NUM_RW_REGS; k++)
      if (ar_idx == IW'(k))
        rd_val = ctrl_q[k];
    for (int j = 0; j < NUM_RO_REGS; j++)
      if (ar_idx == IW'(NUM_RW_REGS + j))
        rd_val = status_i[DW*j +: DW];
    if (!is_map(ar_idx))
      rd_resp = ERR;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rstate    <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q   <= rd_val;
            rresp_q   <= rd_resp;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rstate    <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate    <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_RW_REGS; k++) begin : g_ctrl
    assign ctrl_o[DW*k +: DW] = ctrl_q[k];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse_o    = pulse_q;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_moller_regmap_v2.sv
// Bench for moller_regmap_v2: directed cases plus random traffic vs a word-array model.
module tb_moller_regmap_v2;

`ifdef REGMAP_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic [7:0]   AWADDR = '0;
  logic [2:0]   AWPROT = '0;
  logic         AWVALID = 1'b0;
  logic         AWREADY;
  logic [31:0]  WDATA = '0;
  logic [3:0]   WSTRB = '0;
  logic         WVALID = 1'b0;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY = 1'b0;
  logic [7:0]   ARADDR = '0;
  logic [2:0]   ARPROT = '0;
  logic         ARVALID = 1'b0;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY = 1'b0;
  logic [511:0] ctrl_o;
  logic [15:0]  wr_pulse_o;
  logic [255:0] status_i;

  logic [31:0] mdl [16];
  logic [31:0] st  [8];

  int tests = 0;
  int fails = 0;

  always #5 ACLK = ~ACLK;

  always_comb begin
    status_i = '0;
    for (int j = 0; j < 8; j++) status_i[32*j +: 32] = st[j];
  end

  moller_regmap_v2 dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT),
    .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB),
    .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT),
    .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP),
    .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .ctrl_o(ctrl_o), .wr_pulse_o(wr_pulse_o), .status_i(status_i)
  );

  task automatic check(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [7:0] a);
    int i;
    i = int'(a) / 4;
    if (i < 16) return mdl[i];
    if (i < 24) return st[i-16];
    return 32'h0;
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [7:0] a);
    return (int'(a) / 4 < 24) ? 2'b00 : ERR;
  endfunction

  function automatic logic [1:0] exp_bresp(input logic [7:0] a);
    return (int'(a) / 4 < 16) ? 2'b00 : ERR;
  endfunction

  function automatic logic [15:0] exp_pulse(input logic [7:0] a);
    int i;
    i = int'(a) / 4;
    return (i < 16) ? (16'h1 << i) : 16'h0;
  endfunction

  task automatic mdl_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int i;
    logic [31:0] m;
    i = int'(a) / 4;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (i < 16) mdl[i] = (mdl[i] & ~m) | (d & m);
  endtask

  function automatic logic [511:0] mdl_packed();
    logic [511:0] p;
    for (int k = 0; k < 16; k++) p[32*k +: 32] = mdl[k];
    return p;
  endfunction

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp,
                           output logic [15:0] pulse);
    bit aw_f, w_f;
    int n;
    @(posedge ACLK); #1;
    AWADDR = a; WDATA = d; WSTRB = s;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    n = 0;
    while ((AWVALID || WVALID) && n < 50) begin
      aw_f = AWVALID && AWREADY;
      w_f  = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (aw_f) AWVALID = 1'b0;
      if (w_f)  WVALID  = 1'b0;
      n++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    n = 0;
    while (!BVALID && n < 50) begin
      @(posedge ACLK); #1;
      n++;
    end
    check("bvalid_seen", BVALID, 1'b1);
    resp  = BRESP;
    pulse = wr_pulse_o;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    int n;
    @(posedge ACLK); #1;
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
    n = 0;
    while (ARVALID && n < 50) begin
      if (ARREADY) begin
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
      end else begin
        @(posedge ACLK); #1;
      end
      n++;
    end
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < 50) begin
      @(posedge ACLK); #1;
      n++;
    end
    check("rvalid_seen", RVALID, 1'b1);
    d    = RDATA;
    resp = RRESP;
    @(posedge ACLK); #1;
    RREADY = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  br, rr;
    logic [15:0] pl;
    logic [31:0] rd, rd_old;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;

    for (int k = 0; k < 16; k++) mdl[k] = 32'h0;
    for (int j = 0; j < 8; j++) st[j] = 32'h0;

    // reset state
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_awready", AWREADY, 1'b0);
    check("rst_wready", WREADY, 1'b0);
    check("rst_arready", ARREADY, 1'b0);
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_rvalid", RVALID, 1'b0);
    check("rst_rdata", {RDATA, RRESP, BRESP}, 36'h0);
    check("rst_ctrl", ctrl_o, mdl_packed());
    check("rst_pulse", wr_pulse_o, 16'h0);
    @(negedge ACLK);
    ARESETN = 1'b1;

    // sequential fill and readback of the control bank
    for (int k = 0; k < 16; k++) begin
      a = 8'(4 * k);
      axi_write(a, 32'(k + 1), 4'hF, br, pl);
      mdl_write(a, 32'(k + 1), 4'hF);
      check("t1_bresp", br, 2'b00);
      check("t1_pulse", pl, exp_pulse(a));
    end
    for (int k = 0; k < 16; k++) begin
      a = 8'(4 * k);
      axi_read(a, rd, rr);
      check("t1_rdata", rd, exp_rd(a));
      check("t1_rresp", rr, 2'b00);
    end

    // byte-lane merge
    axi_write(8'h08, 32'hAABBCCDD, 4'hF, br, pl);
    mdl_write(8'h08, 32'hAABBCCDD, 4'hF);
    axi_write(8'h08, 32'h11223344, 4'b0101, br, pl);
    mdl_write(8'h08, 32'h11223344, 4'b0101);
    axi_read(8'h08, rd, rr);
    check("t2_merge", rd, 32'hAA22CC44);
    axi_write(8'h08, 32'h99999999, 4'b0000, br, pl);
    check("t2_zero_strb_pulse", pl, 16'h0004);
    axi_read(8'h08, rd, rr);
    check("t2_zero_strb_data", rd, 32'hAA22CC44);

    // W ahead of AW, BREADY held off
    @(posedge ACLK); #1;
    WDATA = 32'h5A5A0003; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
    AWADDR = 8'h0C;
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    check("t3_wready_low", WREADY, 1'b0);
    repeat (2) @(posedge ACLK);
    #1;
    check("t3_no_early_b", BVALID, 1'b0);
    check("t3_no_early_pulse", wr_pulse_o, 16'h0);
    AWVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    mdl_write(8'h0C, 32'h5A5A0003, 4'hF);
    check("t3_bvalid", BVALID, 1'b1);
    check("t3_pulse", wr_pulse_o, 16'h0008);
    for (int i = 0; i < 5; i++) begin
      @(posedge ACLK); #1;
      check("t3_b_hold", {BVALID, BRESP}, 3'b100);
      check("t3_single_pulse", wr_pulse_o, 16'h0);
    end
    BREADY = 1'b1;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    check("t3_b_done", BVALID, 1'b0);
    axi_read(8'h0C, rd, rr);
    check("t3_data", rd, 32'h5A5A0003);

    // status bank and RO write
    st[0] = 32'hDEADBEEF;
    axi_read(8'h40, rd, rr);
    check("t4_status", rd, 32'hDEADBEEF);
    check("t4_rresp", rr, 2'b00);
    axi_write(8'h40, 32'h12345678, 4'hF, br, pl);
    check("t4_bresp", br, ERR);
    check("t4_pulse", pl, 16'h0);
    axi_read(8'h40, rd, rr);
    check("t4_status_kept", rd, 32'hDEADBEEF);
    check("t4_ctrl", ctrl_o, mdl_packed());

    // unmapped
    axi_read(8'hFC, rd, rr);
    check("t5_rdata", rd, 32'h0);
    check("t5_rresp", rr, ERR);
    axi_write(8'hFC, 32'hFFFFFFFF, 4'hF, br, pl);
    check("t5_bresp", br, ERR);
    check("t5_ctrl", ctrl_o, mdl_packed());

    // same-edge read and write on one register
    rd_old = mdl[5];
    fork
      axi_write(8'h14, 32'hC0FFEE55, 4'hF, br, pl);
      axi_read(8'h14, rd, rr);
    join
    mdl_write(8'h14, 32'hC0FFEE55, 4'hF);
    check("coll_old", rd, rd_old);
    axi_read(8'h14, rd, rr);
    check("coll_new", rd, 32'hC0FFEE55);

    // random traffic
    for (int it = 0; it < 120; it++) begin
      if (it % 15 == 0)
        for (int j = 0; j < 8; j++) st[j] = $urandom;
      a = 8'($urandom_range(0, 255));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        axi_write(a, d, s, br, pl);
        check("rnd_bresp", br, exp_bresp(a));
        check("rnd_pulse", pl, exp_pulse(a));
        mdl_write(a, d, s);
      end else begin
        axi_read(a, rd, rr);
        check("rnd_rdata", rd, exp_rd(a));
        check("rnd_rresp", rr, exp_rresp(a));
      end
    end
    check("rnd_ctrl", ctrl_o, mdl_packed());

    // reset with both responses pending
    @(posedge ACLK); #1;
    AWADDR = 8'h18; WDATA = 32'h0BADF00D; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    ARADDR = 8'h18; ARVALID = 1'b1; RREADY = 1'b0;
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check("t6_pre_b", BVALID, 1'b1);
    check("t6_pre_r", RVALID, 1'b1);
    #2;
    ARESETN = 1'b0;
    #1;
    for (int k = 0; k < 16; k++) mdl[k] = 32'h0;
    check("t6_bvalid", BVALID, 1'b0);
    check("t6_rvalid", RVALID, 1'b0);
    check("t6_ctrl", ctrl_o, mdl_packed());
    check("t6_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
    check("t6_rdata", RDATA, 32'h0);
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    check("t6_no_resp", {BVALID, RVALID}, 2'b00);
    axi_write(8'h18, 32'h600DCAFE, 4'hF, br, pl);
    mdl_write(8'h18, 32'h600DCAFE, 4'hF);
    check("t6_post_bresp", br, 2'b00);
    check("t6_post_pulse", pl, 16'h0040);
    axi_read(8'h18, rd, rr);
    check("t6_post_data", rd, 32'h600DCAFE);
    check("t6_post_ctrl", ctrl_o, mdl_packed());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
